// File: rtl/preadder_pipe.sv
// Handshaked limb-wise pre-adder: two redundant polynomials X, Y in, two
// independently-moded results Z0, Z1 out through one register stage.
// Delayed operands come from a DLY-deep history of accepted beats.

// One limb of one output lane: selects operands by mode and adds them
// modulo 2^W, flagging signed overflow on the addition actually performed.
module preadder_limb #(
    parameter int W = 96
) (
    input  logic [2:0]   mode,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] xd,
    input  logic [W-1:0] yd,
    output logic [W-1:0] z,
    output logic         ovf
);
    logic [W-1:0] a, b, sum;
    logic         chk;

    // Operand select; subtraction is addition of the two's-complement negation
    always_comb begin
        a   = '0;
        b   = '0;
        chk = 1'b0;
        unique case (mode)
            3'd0: a = x;
            3'd1: begin a = x;  b = xd; chk = 1'b1; end
            3'd2: begin a = x;  b = y;  chk = 1'b1; end
            3'd3: begin a = x;  b = -y; chk = 1'b1; end
            3'd4: begin a = y;  b = yd; chk = 1'b1; end
            3'd5: a = y;
            3'd6: begin a = xd; b = -x; chk = 1'b1; end
            default: ;
        endcase
        sum = a + b;
        z   = sum;
        ovf = chk && (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    end
endmodule

module preadder_pipe #(
    parameter int NUM_LIMBS = 3,
    parameter int LIMB_W    = 96,
    parameter int DLY       = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_LIMBS*LIMB_W-1:0] x,
    input  logic [NUM_LIMBS*LIMB_W-1:0] y,
    input  logic [2:0]                  mode0,
    input  logic [2:0]                  mode1,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_LIMBS*LIMB_W-1:0] z0,
    output logic [NUM_LIMBS*LIMB_W-1:0] z1,
    output logic [NUM_LIMBS-1:0]        ovf0,
    output logic [NUM_LIMBS-1:0]        ovf1,
    input  logic                        ovf_clr
);
    localparam int PW = NUM_LIMBS * LIMB_W;
    localparam int CW = $clog2(DLY + 1);

    logic [DLY-1:0][PW-1:0] hx_q, hy_q;
    logic [CW-1:0]          cnt_q;
    logic                   out_valid_q;
    logic [PW-1:0]          z0_q, z1_q, z0_d, z1_d;
    logic [NUM_LIMBS-1:0]   ovf0_q, ovf1_q, ovf0_d, ovf1_d;
    logic [PW-1:0]          xd, yd;
    logic                   accept, warm;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // A flush in the same cycle as a beat hides the old history from that beat
    assign warm = (cnt_q == CW'(DLY)) && !flush;
    assign xd   = warm ? hx_q[DLY-1] : '0;
    assign yd   = warm ? hy_q[DLY-1] : '0;

    // Per-limb, per-lane arithmetic; no carries cross limb boundaries
    for (genvar g = 0; g < NUM_LIMBS; g++) begin : g_limb
        preadder_limb #(.W(LIMB_W)) u_l0 (
            .mode (mode0),
            .x    (x[g*LIMB_W +: LIMB_W]),
            .y    (y[g*LIMB_W +: LIMB_W]),
            .xd   (xd[g*LIMB_W +: LIMB_W]),
            .yd   (yd[g*LIMB_W +: LIMB_W]),
            .z    (z0_d[g*LIMB_W +: LIMB_W]),
            .ovf  (ovf0_d[g])
        );
        preadder_limb #(.W(LIMB_W)) u_l1 (
            .mode (mode1),
            .x    (x[g*LIMB_W +: LIMB_W]),
            .y    (y[g*LIMB_W +: LIMB_W]),
            .xd   (xd[g*LIMB_W +: LIMB_W]),
            .yd   (yd[g*LIMB_W +: LIMB_W]),
            .z    (z1_d[g*LIMB_W +: LIMB_W]),
            .ovf  (ovf1_d[g])
        );
    end

    // History shift and warm-up count advance only on accepted beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hx_q  <= '0;
            hy_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            hx_q  <= '0;
            hy_q  <= '0;
            cnt_q <= '0;
            if (accept) begin
                hx_q[0] <= x;
                hy_q[0] <= y;
                cnt_q   <= CW'(1);
            end
        end else if (accept) begin
            for (int i = DLY - 1; i > 0; i--) begin
                hx_q[i] <= hx_q[i-1];
                hy_q[i] <= hy_q[i-1];
            end
            hx_q[0] <= x;
            hy_q[0] <= y;
            if (cnt_q != CW'(DLY)) cnt_q <= cnt_q + CW'(1);
        end
    end

    // Output stage: load on accept, hold under backpressure, drop when drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            z0_q        <= '0;
            z1_q        <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            z0_q        <= z0_d;
            z1_q        <= z1_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Sticky overflow: set only by accepted beats, and set beats clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf0_q <= '0;
            ovf1_q <= '0;
        end else if (accept) begin
            ovf0_q <= (ovf_clr ? '0 : ovf0_q) | ovf0_d;
            ovf1_q <= (ovf_clr ? '0 : ovf1_q) | ovf1_d;
        end else if (ovf_clr) begin
            ovf0_q <= '0;
            ovf1_q <= '0;
        end
    end

    assign out_valid = out_valid_q;
    assign z0        = z0_q;
    assign z1        = z1_q;
    assign ovf0      = ovf0_q;
    assign ovf1      = ovf1_q;
endmodule

// File: tb/tb_preadder_pipe.sv
// Bench for preadder_pipe: two instances (DLY=1, DLY=2, 8-bit limbs) share
// stimulus and are checked every cycle against a queue-based reference.
module tb_preadder_pipe;
    logic        clk, rst, flush, in_valid, out_ready, ovf_clr;
    logic [23:0] x, y;
    logic [2:0]  mode0, mode1;
    logic        rdy1, ov1, rdy2, ov2;
    logic [23:0] z0_1, z1_1, z0_2, z1_2;
    logic [2:0]  of0_1, of1_1, of0_2, of1_2;

    int errors = 0;
    int checks = 0;

    preadder_pipe #(.NUM_LIMBS(3), .LIMB_W(8), .DLY(1)) u_d1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .x(x), .y(y), .mode0(mode0), .mode1(mode1), .out_valid(ov1),
        .out_ready(out_ready), .z0(z0_1), .z1(z1_1), .ovf0(of0_1), .ovf1(of1_1),
        .ovf_clr(ovf_clr)
    );
    preadder_pipe #(.NUM_LIMBS(3), .LIMB_W(8), .DLY(2)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
        .x(x), .y(y), .mode0(mode0), .mode1(mode1), .out_valid(ov2),
        .out_ready(out_ready), .z0(z0_2), .z1(z1_2), .ovf0(of0_2), .ovf1(of1_2),
        .ovf_clr(ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state: accepted beats since last flush/reset, and output regs
    logic [23:0] qx1[$], qy1[$], qx2[$], qy2[$];
    logic        m_ov;
    logic [23:0] m_z0[2], m_z1[2];
    logic [2:0]  m_of0[2], m_of1[2];

    function automatic logic [23:0] mk(input logic [7:0] l0, l1, l2);
        return {l2, l1, l0};
    endfunction

    function automatic logic [8:0] add8(input logic [7:0] a, b);
        logic [7:0] s;
        s = a + b;
        return {(a[7] == b[7]) && (s[7] != a[7]), s};
    endfunction

    function automatic logic [7:0] neg8(input logic [7:0] a);
        return ~a + 8'd1;
    endfunction

    function automatic logic [26:0] poly(input logic [2:0] m, input logic [23:0] X, Y, Xd, Yd);
        logic [23:0] z;
        logic [2:0]  o;
        logic [8:0]  r;
        logic [7:0]  xl, yl, xdl, ydl;
        z = '0;
        o = '0;
        for (int l = 0; l < 3; l++) begin
            xl  = X[l*8 +: 8];
            yl  = Y[l*8 +: 8];
            xdl = Xd[l*8 +: 8];
            ydl = Yd[l*8 +: 8];
            case (m)
                3'd0: r = {1'b0, xl};
                3'd1: r = add8(xl, xdl);
                3'd2: r = add8(xl, yl);
                3'd3: r = add8(xl, neg8(yl));
                3'd4: r = add8(yl, ydl);
                3'd5: r = {1'b0, yl};
                3'd6: r = add8(xdl, neg8(xl));
                default: r = '0;
            endcase
            z[l*8 +: 8] = r[7:0];
            o[l]        = r[8];
        end
        return {o, z};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qx1.delete(); qy1.delete(); qx2.delete(); qy2.delete();
        m_ov = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_z0[k] = '0; m_z1[k] = '0; m_of0[k] = '0; m_of1[k] = '0;
        end
    endtask

    task automatic check_outs();
        chk("out_valid1", ov1, m_ov);
        chk("out_valid2", ov2, m_ov);
        chk("z0_d1", z0_1, m_z0[0]);
        chk("z1_d1", z1_1, m_z1[0]);
        chk("ovf0_d1", of0_1, m_of0[0]);
        chk("ovf1_d1", of1_1, m_of1[0]);
        chk("z0_d2", z0_2, m_z0[1]);
        chk("z1_d2", z1_2, m_z1[1]);
        chk("ovf0_d2", of0_2, m_of0[1]);
        chk("ovf1_d2", of1_2, m_of1[1]);
    endtask

    // Apply current inputs for one clock, advance the reference, compare after the edge
    task automatic cycle();
        logic        acc;
        logic [23:0] xd[2], yd[2];
        logic [26:0] r0, r1;
        #1;
        chk("in_ready1", rdy1, !m_ov || out_ready);
        chk("in_ready2", rdy2, !m_ov || out_ready);
        acc = in_valid && (!m_ov || out_ready);
        if (flush) begin
            qx1.delete(); qy1.delete(); qx2.delete(); qy2.delete();
        end
        xd[0] = (qx1.size() >= 1) ? qx1[qx1.size()-1] : '0;
        yd[0] = (qy1.size() >= 1) ? qy1[qy1.size()-1] : '0;
        xd[1] = (qx2.size() >= 2) ? qx2[qx2.size()-2] : '0;
        yd[1] = (qy2.size() >= 2) ? qy2[qy2.size()-2] : '0;
        if (acc) begin
            for (int k = 0; k < 2; k++) begin
                r0 = poly(mode0, x, y, xd[k], yd[k]);
                r1 = poly(mode1, x, y, xd[k], yd[k]);
                m_z0[k]  = r0[23:0];
                m_z1[k]  = r1[23:0];
                m_of0[k] = (ovf_clr ? 3'b000 : m_of0[k]) | r0[26:24];
                m_of1[k] = (ovf_clr ? 3'b000 : m_of1[k]) | r1[26:24];
            end
            m_ov = 1'b1;
            qx1.push_back(x); qy1.push_back(y); qx2.push_back(x); qy2.push_back(y);
            while (qx1.size() > 1) begin void'(qx1.pop_front()); void'(qy1.pop_front()); end
            while (qx2.size() > 2) begin void'(qx2.pop_front()); void'(qy2.pop_front()); end
        end else begin
            if (out_ready) m_ov = 1'b0;
            if (ovf_clr) begin
                m_of0[0] = '0; m_of1[0] = '0; m_of0[1] = '0; m_of1[1] = '0;
            end
        end
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic beat(input logic [23:0] bx, by, input logic [2:0] m0, m1);
        in_valid = 1'b1; x = bx; y = by; mode0 = m0; mode1 = m1;
        cycle();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        x = '0; y = '0; mode0 = '0; mode1 = '0;
        model_reset();
        #12;
        chk("rst_out_valid", ov1, 1'b0);
        chk("rst_z0", z0_1, 24'h0);
        chk("rst_ovf0", of0_1, 3'b000);
        check_outs();
        rst = 1'b0;

        // Basic add / subtract
        beat(mk(1, 2, 3), mk(1, 1, 1), 3'd2, 3'd3);
        chk("t1_valid", ov1, 1'b1);
        chk("t1_z0", z0_1, mk(2, 3, 4));
        chk("t1_z1", z1_1, mk(0, 1, 2));
        chk("t1_ovf", {of0_1, of1_1}, 6'b0);

        // Flush coincident with a beat: that beat sees zero history
        flush = 1'b1;
        beat(mk(5, 5, 5), mk(1, 1, 1), 3'd1, 3'd3);
        flush = 1'b0;
        chk("warm_z0", z0_1, mk(5, 5, 5));
        beat(mk(1, 0, 7), mk(1, 1, 1), 3'd1, 3'd3);
        chk("acc_z0", z0_1, mk(6, 5, 12));

        // Backpressure: stalled beat must not enter history
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(mk(9, 9, 9), mk(1, 1, 1), 3'd1, 3'd3);
            chk("stall_ready", rdy1, 1'b0);
            chk("stall_z0", z0_1, mk(6, 5, 12));
        end
        out_ready = 1'b1;
        beat(mk(2, 2, 2), mk(1, 1, 1), 3'd1, 3'd3);
        chk("release_z0", z0_1, mk(3, 2, 9));
        in_valid = 1'b0;
        cycle();
        chk("drain_valid", ov1, 1'b0);

        // Overflow set / sticky / clear / set-wins
        beat(mk(8'h7F, 0, 0), mk(1, 0, 0), 3'd2, 3'd0);
        chk("ovf_z0", z0_1, mk(8'h80, 0, 0));
        chk("ovf_set", of0_1, 3'b001);
        chk("ovf_lane1", of1_1, 3'b000);
        beat(mk(1, 1, 1), mk(0, 0, 0), 3'd2, 3'd0);
        chk("ovf_sticky", of0_1, 3'b001);
        in_valid = 1'b0; ovf_clr = 1'b1;
        cycle();
        chk("ovf_clr", of0_1, 3'b000);
        beat(mk(8'h7F, 0, 0), mk(1, 0, 0), 3'd2, 3'd0);
        ovf_clr = 1'b0;
        chk("ovf_set_wins", of0_1, 3'b001);

        // DLY=2 accumulate, with and without an intervening flush
        in_valid = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        beat(mk(0, 0, 0), mk(1, 2, 3), 3'd0, 3'd4);
        beat(mk(0, 0, 0), mk(10, 10, 10), 3'd0, 3'd4);
        beat(mk(0, 0, 0), mk(4, 4, 4), 3'd0, 3'd4);
        chk("dly2_z1", z1_2, mk(5, 6, 7));
        in_valid = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        beat(mk(0, 0, 0), mk(1, 2, 3), 3'd0, 3'd4);
        beat(mk(0, 0, 0), mk(10, 10, 10), 3'd0, 3'd4);
        in_valid = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        beat(mk(0, 0, 0), mk(4, 4, 4), 3'd0, 3'd4);
        chk("dly2_flush_z1", z1_2, mk(4, 4, 4));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            mode0     = 3'($urandom_range(0, 7));
            mode1     = 3'($urandom_range(0, 7));
            x         = 24'($urandom);
            y         = 24'($urandom);
            cycle();
        end
        flush = 1'b0; ovf_clr = 1'b0;

        // Reset mid-stall
        out_ready = 1'b0;
        beat(mk(8'h7F, 3, 3), mk(1, 1, 1), 3'd2, 3'd4);
        beat(mk(8'h7F, 3, 3), mk(1, 1, 1), 3'd2, 3'd4);
        chk("pre_rst_valid", ov1, 1'b1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_valid", ov1, 1'b0);
        chk("async_rst_z1", z1_2, 24'h0);
        check_outs();
        rst = 1'b0;
        out_ready = 1'b1;
        beat(mk(7, 8, 9), mk(3, 3, 3), 3'd1, 3'd4);
        chk("post_rst_z0", z0_1, mk(7, 8, 9));
        chk("post_rst_z1", z1_2, mk(3, 3, 3));
        in_valid = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
